// File: rtl/vc_pkg.sv
// -----------------------------------------------------------------------------
// vc_pkg
// Shared definitions for the victim-cache controller:
//   - default geometry (tag width, number of ways)
//   - statistics counter width
//   - controller state encoding
//   - saturating increment helper for the statistics counters
// -----------------------------------------------------------------------------
package vc_pkg;

   localparam int VC_TAG_WIDTH = 4;
   localparam int VC_NUM_WAYS  = 4;
   localparam int VC_STAT_W    = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_RESP   = 3'd2,
      ST_SELECT = 3'd3,
      ST_WB     = 3'd4,
      ST_WRITE  = 3'd5,
      ST_MARK   = 3'd6
   } vc_state_e;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [VC_STAT_W-1:0] vc_sat_inc(input logic [VC_STAT_W-1:0] v);
      if (v == {VC_STAT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(VC_STAT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/vc_victim_sel.sv
// -----------------------------------------------------------------------------
// vc_victim_sel
// Combinational replacement-way chooser for an insert.
//   valid_vec_i / dirty_vec_i : per-way state from the tag store
//   hit_i / hit_way_i         : tag-store probe result for the inserted tag
//   rr_ptr_i                  : round-robin fallback pointer
//   way_o                     : chosen way
//   need_wb_o                 : chosen way holds a dirty line that must leave first
//   use_rr_o                  : the round-robin pointer was consumed
// Priority: hit way, then lowest-index invalid way, then round-robin.
// -----------------------------------------------------------------------------
module vc_victim_sel
   import vc_pkg::*;
#(
   parameter  int NUM_WAYS = VC_NUM_WAYS,
   localparam int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0] valid_vec_i,
   input  logic [NUM_WAYS-1:0] dirty_vec_i,
   input  logic                hit_i,
   input  logic [WAY_W-1:0]    hit_way_i,
   input  logic [WAY_W-1:0]    rr_ptr_i,
   output logic [WAY_W-1:0]    way_o,
   output logic                need_wb_o,
   output logic                use_rr_o
);

   function automatic logic [WAY_W-1:0] first_invalid(input logic [NUM_WAYS-1:0] v);
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (!v[i]) begin
            return WAY_W'(i);
         end
      end
      return '0;
   endfunction

   logic any_invalid_s;

   assign any_invalid_s = ~(&valid_vec_i);

   // Way choice and writeback decision.
   always_comb begin
      way_o     = '0;
      use_rr_o  = 1'b0;
      need_wb_o = 1'b0;
      if (hit_i) begin
         way_o = hit_way_i;
      end else if (any_invalid_s) begin
         way_o = first_invalid(valid_vec_i);
      end else begin
         way_o    = rr_ptr_i;
         use_rr_o = 1'b1;
      end
      // A hit overwrites its own line, so it never needs a writeback.
      need_wb_o = ~hit_i & valid_vec_i[way_o] & dirty_vec_i[way_o];
   end

endmodule

// File: rtl/victim_cache_ctrl.sv
// -----------------------------------------------------------------------------
// victim_cache_ctrl
// Sequencer for the victim-cache tag store. Serves L1 miss lookups (probe and
// migrate a hit line back to L1 by invalidating it) and L1 evictions (insert,
// with replacement-way choice and a dirty-victim writeback handshake).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   lk_*                  lookup request/accept and one-cycle response
//   ev_*                  insert request/accept and one-cycle completion
//   wb_*                  dirty-victim writeback valid/ready handshake
//   ts_*_o                tag-store controls, tag and way (one control per cycle)
//   ts_*_i                tag-store hit, hit way, valid and dirty vectors
//   stat_*_o              hit/miss/writeback counters (only with VC_STATS_EN)
//
// Build option: define VC_STATS_EN to add saturating 16-bit statistics
// counters and their output ports.
// -----------------------------------------------------------------------------
module victim_cache_ctrl
   import vc_pkg::*;
#(
   parameter  int TAG_WIDTH = VC_TAG_WIDTH,
   parameter  int NUM_WAYS  = VC_NUM_WAYS,
   localparam int WAY_W     = $clog2(NUM_WAYS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 lk_req_i,
   input  logic [TAG_WIDTH-1:0] lk_tag_i,
   output logic                 lk_ready_o,
   output logic                 resp_valid_o,
   output logic                 resp_hit_o,
   output logic [WAY_W-1:0]     resp_way_o,
   output logic                 resp_dirty_o,
   input  logic                 ev_req_i,
   input  logic [TAG_WIDTH-1:0] ev_tag_i,
   input  logic                 ev_dirty_i,
   output logic                 ev_ready_o,
   output logic                 ev_done_o,
   output logic [WAY_W-1:0]     ev_way_o,
   output logic                 wb_valid_o,
   output logic [WAY_W-1:0]     wb_way_o,
   input  logic                 wb_ready_i,
   output logic                 ts_write_en_o,
   output logic                 ts_read_en_o,
   output logic                 ts_lookup_en_o,
   output logic                 ts_valid_clear_o,
   output logic                 ts_dirty_set_o,
   output logic                 ts_dirty_clear_o,
   output logic [TAG_WIDTH-1:0] ts_tag_o,
   output logic [WAY_W-1:0]     ts_way_o,
   input  logic                 ts_hit_i,
   input  logic [WAY_W-1:0]     ts_hit_way_i,
   input  logic [NUM_WAYS-1:0]  ts_valid_vec_i,
   input  logic [NUM_WAYS-1:0]  ts_dirty_vec_i
`ifdef VC_STATS_EN
   ,
   output logic [VC_STAT_W-1:0] stat_hits_o,
   output logic [VC_STAT_W-1:0] stat_misses_o,
   output logic [VC_STAT_W-1:0] stat_wbs_o
`endif
);

   vc_state_e            state_q;
   logic                 idle_q;      // IDLE and out of reset: requests may be accepted
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 ev_dirty_q;
   logic                 merged_q;    // line must end up dirty after the write
   logic [WAY_W-1:0]     way_q;
   logic [WAY_W-1:0]     rr_ptr_q;
   logic [WAY_W-1:0]     rr_ptr_d;

   logic                 resp_valid_q, resp_hit_q, resp_dirty_q;
   logic [WAY_W-1:0]     resp_way_q;
   logic                 ev_done_q;
   logic [WAY_W-1:0]     ev_way_q;
   logic                 wb_valid_q;
   logic [WAY_W-1:0]     wb_way_q;
   logic                 ts_write_en_q, ts_lookup_en_q, ts_valid_clear_q, ts_dirty_set_q;
   logic [TAG_WIDTH-1:0] ts_tag_q;
   logic [WAY_W-1:0]     ts_way_q;

   logic                 lk_accept_s, ev_accept_s;
   logic [WAY_W-1:0]     sel_way_s;
   logic                 sel_need_wb_s, sel_use_rr_s;
   logic                 merged_d;

   vc_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_sel (
      .valid_vec_i (ts_valid_vec_i),
      .dirty_vec_i (ts_dirty_vec_i),
      .hit_i       (ts_hit_i),
      .hit_way_i   (ts_hit_way_i),
      .rr_ptr_i    (rr_ptr_q),
      .way_o       (sel_way_s),
      .need_wb_o   (sel_need_wb_s),
      .use_rr_o    (sel_use_rr_s)
   );

   // Lookup wins over insert when both request in the same cycle.
   assign lk_accept_s = idle_q & lk_req_i;
   assign ev_accept_s = idle_q & ~lk_req_i & ev_req_i;

   // Next round-robin pointer (wraps naturally, NUM_WAYS is a power of 2) and
   // merged dirty state for an insert that hits an existing line.
   always_comb begin
      rr_ptr_d = rr_ptr_q + {{(WAY_W-1){1'b0}}, 1'b1};
      merged_d = ev_dirty_q | (ts_hit_i & ts_dirty_vec_i[ts_hit_way_i]);
   end

   assign lk_ready_o       = idle_q;
   assign ev_ready_o       = idle_q & ~lk_req_i;
   assign resp_valid_o     = resp_valid_q;
   assign resp_hit_o       = resp_hit_q;
   assign resp_way_o       = resp_way_q;
   assign resp_dirty_o     = resp_dirty_q;
   assign ev_done_o        = ev_done_q;
   assign ev_way_o         = ev_way_q;
   assign wb_valid_o       = wb_valid_q;
   assign wb_way_o         = wb_way_q;
   assign ts_write_en_o    = ts_write_en_q;
   assign ts_read_en_o     = 1'b0;
   assign ts_lookup_en_o   = ts_lookup_en_q;
   assign ts_valid_clear_o = ts_valid_clear_q;
   assign ts_dirty_set_o   = ts_dirty_set_q;
   assign ts_dirty_clear_o = 1'b0;
   assign ts_tag_o         = ts_tag_q;
   assign ts_way_o         = ts_way_q;

   // Controller FSM; every output is registered and set on entry to the
   // state in which it must be visible.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= ST_IDLE;
         idle_q           <= 1'b0;
         tag_q            <= '0;
         ev_dirty_q       <= 1'b0;
         merged_q         <= 1'b0;
         way_q            <= '0;
         rr_ptr_q         <= '0;
         resp_valid_q     <= 1'b0;
         resp_hit_q       <= 1'b0;
         resp_way_q       <= '0;
         resp_dirty_q     <= 1'b0;
         ev_done_q        <= 1'b0;
         ev_way_q         <= '0;
         wb_valid_q       <= 1'b0;
         wb_way_q         <= '0;
         ts_write_en_q    <= 1'b0;
         ts_lookup_en_q   <= 1'b0;
         ts_valid_clear_q <= 1'b0;
         ts_dirty_set_q   <= 1'b0;
         ts_tag_q         <= '0;
         ts_way_q         <= '0;
      end else begin
         resp_valid_q     <= 1'b0;
         resp_hit_q       <= 1'b0;
         resp_way_q       <= '0;
         resp_dirty_q     <= 1'b0;
         ev_done_q        <= 1'b0;
         ev_way_q         <= '0;
         ts_write_en_q    <= 1'b0;
         ts_lookup_en_q   <= 1'b0;
         ts_valid_clear_q <= 1'b0;
         ts_dirty_set_q   <= 1'b0;
         ts_tag_q         <= '0;
         ts_way_q         <= '0;
         case (state_q)
            ST_IDLE: begin
               if (lk_accept_s) begin
                  tag_q          <= lk_tag_i;
                  idle_q         <= 1'b0;
                  ts_lookup_en_q <= 1'b1;
                  ts_tag_q       <= lk_tag_i;
                  state_q        <= ST_LOOKUP;
               end else if (ev_accept_s) begin
                  tag_q          <= ev_tag_i;
                  ev_dirty_q     <= ev_dirty_i;
                  idle_q         <= 1'b0;
                  ts_lookup_en_q <= 1'b1;
                  ts_tag_q       <= ev_tag_i;
                  state_q        <= ST_SELECT;
               end else begin
                  idle_q <= 1'b1;
               end
            end
            ST_LOOKUP: begin
               // Exclusive cache: a hit line leaves the victim cache.
               resp_valid_q     <= 1'b1;
               resp_hit_q       <= ts_hit_i;
               resp_way_q       <= ts_hit_i ? ts_hit_way_i : '0;
               resp_dirty_q     <= ts_hit_i & ts_dirty_vec_i[ts_hit_way_i];
               ts_valid_clear_q <= ts_hit_i;
               ts_way_q         <= ts_hit_i ? ts_hit_way_i : '0;
               state_q          <= ST_RESP;
            end
            ST_RESP: begin
               idle_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            ST_SELECT: begin
               way_q    <= sel_way_s;
               merged_q <= merged_d;
               if (sel_use_rr_s) begin
                  rr_ptr_q <= rr_ptr_d;
               end
               if (sel_need_wb_s) begin
                  wb_valid_q <= 1'b1;
                  wb_way_q   <= sel_way_s;
                  state_q    <= ST_WB;
               end else begin
                  ts_write_en_q <= 1'b1;
                  ts_tag_q      <= tag_q;
                  ts_way_q      <= sel_way_s;
                  ev_done_q     <= ~merged_d;
                  ev_way_q      <= merged_d ? '0 : sel_way_s;
                  state_q       <= ST_WRITE;
               end
            end
            ST_WB: begin
               if (wb_ready_i) begin
                  wb_valid_q    <= 1'b0;
                  wb_way_q      <= '0;
                  ts_write_en_q <= 1'b1;
                  ts_tag_q      <= tag_q;
                  ts_way_q      <= way_q;
                  ev_done_q     <= ~merged_q;
                  ev_way_q      <= merged_q ? '0 : way_q;
                  state_q       <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (merged_q) begin
                  ts_dirty_set_q <= 1'b1;
                  ts_way_q       <= way_q;
                  ev_done_q      <= 1'b1;
                  ev_way_q       <= way_q;
                  state_q        <= ST_MARK;
               end else begin
                  idle_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_MARK: begin
               idle_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               idle_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef VC_STATS_EN
   logic [VC_STAT_W-1:0] stat_hits_q, stat_misses_q, stat_wbs_q;

   // Hit/miss counted in the response cycle, writebacks on the transfer cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_hits_q   <= '0;
         stat_misses_q <= '0;
         stat_wbs_q    <= '0;
      end else begin
         if (state_q == ST_RESP) begin
            if (resp_hit_q) begin
               stat_hits_q <= vc_sat_inc(stat_hits_q);
            end else begin
               stat_misses_q <= vc_sat_inc(stat_misses_q);
            end
         end
         if ((state_q == ST_WB) && wb_ready_i) begin
            stat_wbs_q <= vc_sat_inc(stat_wbs_q);
         end
      end
   end

   assign stat_hits_o   = stat_hits_q;
   assign stat_misses_o = stat_misses_q;
   assign stat_wbs_o    = stat_wbs_q;
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;
   localparam int TW = 4;
   localparam int NW = 4;
   localparam int WW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lk_req = 1'b0;
   logic [TW-1:0] lk_tag = '0;
   logic          lk_ready, resp_valid, resp_hit, resp_dirty;
   logic [WW-1:0] resp_way;
   logic          ev_req = 1'b0;
   logic [TW-1:0] ev_tag = '0;
   logic          ev_dirty = 1'b0;
   logic          ev_ready, ev_done;
   logic [WW-1:0] ev_way;
   logic          wb_valid;
   logic [WW-1:0] wb_way;
   logic          wb_ready = 1'b0;
   logic          ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
   logic [TW-1:0] ts_tag;
   logic [WW-1:0] ts_way;
   logic          ts_hit;
   logic [WW-1:0] ts_hit_way;
`ifdef VC_STATS_EN
   logic [15:0]   stat_hits, stat_misses, stat_wbs;
`endif

   // Tag-store stand-in driven by the controller's outputs.
   logic [NW-1:0] env_valid = '0;
   logic [NW-1:0] env_dirty = '0;
   logic [TW-1:0] env_tag [NW];

   // Transaction-level reference model.
   bit ref_valid [NW];
   bit ref_dirty [NW];
   int ref_tag   [NW];
   int ref_rr = 0;
   int ref_hits = 0, ref_misses = 0, ref_wbs = 0;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   victim_cache_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .lk_req_i(lk_req), .lk_tag_i(lk_tag), .lk_ready_o(lk_ready),
      .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_way_o(resp_way), .resp_dirty_o(resp_dirty),
      .ev_req_i(ev_req), .ev_tag_i(ev_tag), .ev_dirty_i(ev_dirty), .ev_ready_o(ev_ready),
      .ev_done_o(ev_done), .ev_way_o(ev_way),
      .wb_valid_o(wb_valid), .wb_way_o(wb_way), .wb_ready_i(wb_ready),
      .ts_write_en_o(ts_write_en), .ts_read_en_o(ts_read_en), .ts_lookup_en_o(ts_lookup_en),
      .ts_valid_clear_o(ts_valid_clear), .ts_dirty_set_o(ts_dirty_set), .ts_dirty_clear_o(ts_dirty_clear),
      .ts_tag_o(ts_tag), .ts_way_o(ts_way),
      .ts_hit_i(ts_hit), .ts_hit_way_i(ts_hit_way),
      .ts_valid_vec_i(env_valid), .ts_dirty_vec_i(env_dirty)
`ifdef VC_STATS_EN
      , .stat_hits_o(stat_hits), .stat_misses_o(stat_misses), .stat_wbs_o(stat_wbs)
`endif
   );

   always @(posedge clk) begin
      if (ts_write_en) begin
         env_valid[ts_way] <= 1'b1;
         env_dirty[ts_way] <= 1'b0;
         env_tag[ts_way]   <= ts_tag;
      end
      if (ts_valid_clear) env_valid[ts_way] <= 1'b0;
      if (ts_dirty_set)   env_dirty[ts_way] <= 1'b1;
   end

   always_comb begin
      ts_hit     = 1'b0;
      ts_hit_way = '0;
      for (int i = 0; i < NW; i++) begin
         if (ts_lookup_en && env_valid[i] && (env_tag[i] == ts_tag)) begin
            ts_hit     = 1'b1;
            ts_hit_way = WW'(i);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // At most one tag-store control per cycle.
   always @(negedge clk) begin
      if (!rst)
         check("ts_onehot", 32'($countones({ts_write_en, ts_read_en, ts_lookup_en,
                                             ts_valid_clear, ts_dirty_set, ts_dirty_clear}) <= 1), 32'd1);
   end

   task automatic compare_store();
      for (int i = 0; i < NW; i++) begin
         check("store_valid", 32'(env_valid[i]), 32'(ref_valid[i]));
         if (ref_valid[i]) begin
            check("store_dirty", 32'(env_dirty[i]), 32'(ref_dirty[i]));
            check("store_tag", 32'(env_tag[i]), 32'(ref_tag[i]));
         end
      end
   endtask

   task automatic do_lookup(input logic [TW-1:0] tag);
      bit h = 0; bit d = 0; int w = 0; int n = 0;
      for (int i = 0; i < NW; i++)
         if (ref_valid[i] && ref_tag[i] == int'(tag)) begin h = 1; w = i; d = ref_dirty[i]; end
      lk_req = 1'b1; lk_tag = tag; #1;
      while (!lk_ready && n < 10) begin @(negedge clk); #1; n++; end
      check("lk_ready", 32'(lk_ready), 32'd1);
      @(negedge clk); lk_req = 1'b0;
      check("lk_lookup_en", 32'(ts_lookup_en), 32'd1);
      check("lk_ts_tag", 32'(ts_tag), 32'(tag));
      check("lk_resp_early", 32'(resp_valid), 32'd0);
      check("lk_ev_ready_busy", 32'(ev_ready), 32'd0);
      @(negedge clk);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_hit", 32'(resp_hit), 32'(h));
      check("resp_way", 32'(resp_way), 32'(w));
      check("resp_dirty", 32'(resp_dirty), 32'(d));
      check("resp_valid_clear", 32'(ts_valid_clear), 32'(h));
      check("resp_ev_ready_busy", 32'(ev_ready), 32'd0);
      if (h) check("resp_clear_way", 32'(ts_way), 32'(w));
      if (h) begin ref_valid[w] = 0; ref_hits++; end
      else ref_misses++;
      @(negedge clk);
      check("resp_strobe_drop", 32'(resp_valid), 32'd0);
      compare_store();
   endtask

   task automatic do_insert(input logic [TW-1:0] tag, input bit dirty, input int delay);
      bit h = 0; bit inv = 0; bit need_wb; bit merged; int w = 0; int n = 0;
      for (int i = 0; i < NW; i++)
         if (ref_valid[i] && ref_tag[i] == int'(tag)) begin h = 1; w = i; end
      if (!h) begin
         for (int i = NW - 1; i >= 0; i--)
            if (!ref_valid[i]) begin inv = 1; w = i; end
         if (!inv) begin w = ref_rr; ref_rr = (ref_rr + 1) % NW; end
      end
      need_wb = !h && ref_valid[w] && ref_dirty[w];
      merged  = dirty || (h && ref_dirty[w]);
      ev_req = 1'b1; ev_tag = tag; ev_dirty = dirty; #1;
      while (!ev_ready && n < 10) begin @(negedge clk); #1; n++; end
      check("ev_ready", 32'(ev_ready), 32'd1);
      @(negedge clk); ev_req = 1'b0;
      check("sel_lookup_en", 32'(ts_lookup_en), 32'd1);
      check("sel_ts_tag", 32'(ts_tag), 32'(tag));
      check("sel_ev_ready_busy", 32'(ev_ready), 32'd0);
      @(negedge clk);
      check("wb_valid", 32'(wb_valid), 32'(need_wb));
      if (need_wb) begin
         check("wb_way", 32'(wb_way), 32'(w));
         for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("wb_valid_hold", 32'(wb_valid), 32'd1);
            check("wb_way_hold", 32'(wb_way), 32'(w));
            check("wb_no_write", 32'(ts_write_en), 32'd0);
         end
         wb_ready = 1'b1;
         @(negedge clk); wb_ready = 1'b0;
         ref_wbs++;
         check("wb_drop", 32'(wb_valid), 32'd0);
      end
      check("wr_write_en", 32'(ts_write_en), 32'd1);
      check("wr_way", 32'(ts_way), 32'(w));
      check("wr_tag", 32'(ts_tag), 32'(tag));
      check("wr_ev_done", 32'(ev_done), 32'(!merged));
      if (!merged) check("wr_ev_way", 32'(ev_way), 32'(w));
      if (merged) begin
         @(negedge clk);
         check("mark_dirty_set", 32'(ts_dirty_set), 32'd1);
         check("mark_way", 32'(ts_way), 32'(w));
         check("mark_ev_done", 32'(ev_done), 32'd1);
         check("mark_ev_way", 32'(ev_way), 32'(w));
      end
      ref_valid[w] = 1; ref_tag[w] = int'(tag); ref_dirty[w] = merged;
      @(negedge clk);
      check("ev_done_drop", 32'(ev_done), 32'd0);
      compare_store();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < NW; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = 0; end
      // Reset: all outputs low.
      repeat (3) @(negedge clk);
      check("rst_lk_ready", 32'(lk_ready), 32'd0);
      check("rst_ev_ready", 32'(ev_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_ev_done", 32'(ev_done), 32'd0);
      check("rst_ts_ctrl", 32'({ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Miss on empty store.
      do_lookup(4'h5);
      // Fill ways 0..3 cleanly.
      do_insert(4'h1, 1'b0, 0);
      do_insert(4'h2, 1'b0, 0);
      do_insert(4'h3, 1'b0, 0);
      do_insert(4'h4, 1'b0, 0);
      // Make way 0 dirty via a hit-merge, then force a writeback of way 0.
      do_insert(4'h1, 1'b1, 0);
      do_insert(4'h9, 1'b0, 3);
      // Way 2 dirty, then look it up.
      do_insert(4'h3, 1'b1, 0);
      do_lookup(4'h3);
      // Simultaneous requests: lookup first, then dirty insert.
      lk_req = 1'b1; lk_tag = 4'h7; ev_req = 1'b1; ev_tag = 4'hA; ev_dirty = 1'b1; #1;
      check("simul_lk_ready", 32'(lk_ready), 32'd1);
      check("simul_ev_ready", 32'(ev_ready), 32'd0);
      do_lookup(4'h7);
      do_insert(4'hA, 1'b1, 0);

      // Reset in the middle of a writeback.
      do_insert(4'h2, 1'b1, 0);
      ev_req = 1'b1; ev_tag = 4'hB; ev_dirty = 1'b0; #1;
      n = 0;
      while (!ev_ready && n < 10) begin @(negedge clk); #1; n++; end
      @(negedge clk); ev_req = 1'b0;
      @(negedge clk);
      check("rstwb_wb_valid", 32'(wb_valid), 32'd1);
      check("rstwb_wb_way", 32'(wb_way), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rstwb_wb_drop", 32'(wb_valid), 32'd0);
      check("rstwb_ev_done", 32'(ev_done), 32'd0);
      check("rstwb_resp", 32'(resp_valid), 32'd0);
      check("rstwb_write", 32'(ts_write_en), 32'd0);
      ref_rr = 0; ref_hits = 0; ref_misses = 0; ref_wbs = 0;
`ifdef VC_STATS_EN
      check("rstwb_stat_hits", 32'(stat_hits), 32'd0);
      check("rstwb_stat_misses", 32'(stat_misses), 32'd0);
      check("rstwb_stat_wbs", 32'(stat_wbs), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      compare_store();
      // Round-robin restarts at way 0.
      do_insert(4'hB, 1'b0, 0);

      // Randomized traffic against the reference model.
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 1) == 0)
            do_lookup(4'($urandom_range(0, 7)));
         else
            do_insert(4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

`ifdef VC_STATS_EN
      check("stat_hits", 32'(stat_hits), 32'(ref_hits));
      check("stat_misses", 32'(stat_misses), 32'(ref_misses));
      check("stat_wbs", 32'(stat_wbs), 32'(ref_wbs));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
- Sequencing controller for the victim-cache tag store; sole master of its write/read/lookup/valid_clear/dirty_set/dirty_clear controls.
- Serves two requesters:
  - L1 miss lookups: probe the victim cache and migrate a hit line back to L1.
  - L1 evictions: insert a line, choosing a replacement way and issuing a dirty-victim writeback handshake first.
- Sits between the L1 miss/evict path and the tag_store/data-array pair.

Parameters:
- TAG_WIDTH, 4, tag bits; must match the tag store.
- NUM_WAYS, 4, number of ways; power of 2, at least 2. WAY_W = $clog2(NUM_WAYS).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- lk_req  in  1  lookup request.
- lk_tag  in  TAG_WIDTH  lookup tag.
- lk_ready  out  1  lookup accepted when lk_req & lk_ready.
- resp_valid  out  1  one-cycle lookup response strobe.
- resp_hit  out  1  lookup hit.
- resp_way  out  WAY_W  hit way (0 on miss).
- resp_dirty  out  1  hit line was dirty.
- ev_req  in  1  eviction/insert request.
- ev_tag  in  TAG_WIDTH  tag to insert.
- ev_dirty  in  1  inserted line is dirty.
- ev_ready  out  1  insert accepted when ev_req & ev_ready.
- ev_done  out  1  one-cycle strobe when the insert completes.
- ev_way  out  WAY_W  way written; valid with ev_done.
- wb_valid  out  1  dirty victim writeback request.
- wb_way  out  WAY_W  way to write back.
- wb_ready  in  1  writeback accepted.
- ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear  out  1 each  tag-store controls.
- ts_tag  out  TAG_WIDTH  tag-store tag_in.
- ts_way  out  WAY_W  tag-store way_index_in.
- ts_hit  in  1  tag-store hit.
- ts_hit_way  in  WAY_W  tag-store hit way.
- ts_valid_vec  in  NUM_WAYS  tag-store valid vector.
- ts_dirty_vec  in  NUM_WAYS  tag-store dirty vector.

Behaviour:
- Reset (sync, rst=1): state IDLE, rr_ptr=0, every output 0. Reset mid-operation aborts the transaction; wb_valid drops in the next cycle; no strobe is emitted.
- Ready signals:
  - lk_ready=1 only in IDLE.
  - ev_ready=1 only in IDLE and when lk_req=0. Lookup has priority on simultaneous requests.
- On acceptance, the tag and dirty flag are captured into registers. At most one ts_* control is high per cycle.
- IDLE: on lookup accept go to LOOKUP; on insert accept go to SELECT.
- LOOKUP (1 cycle):
  - Drive ts_lookup_en=1 and ts_tag=captured tag.
  - Register ts_hit, ts_hit_way, ts_dirty_vec[ts_hit_way].
  - Go to RESP.
- RESP (1 cycle):
  - resp_valid=1 with the registered hit/way/dirty.
  - On a hit, also drive ts_valid_clear=1, ts_way=hit way (exclusive cache: the line migrates to L1).
  - Go to IDLE. Lookup latency: accept at cycle T, resp_valid at T+2.
- SELECT (1 cycle):
  - Drive ts_lookup_en=1 with the captured tag. Way choice, in priority order:
    1. ts_hit: reuse the hit way; no writeback; merged dirty = ev_dirty | old dirty.
    2. Otherwise, the lowest-index invalid way.
    3. Otherwise, rr_ptr; then rr_ptr increments and wraps NUM_WAYS-1 to 0.
  - If the chosen way is valid, dirty and not a hit, go to WB; else go to WRITE.
- WB:
  - wb_valid=1 and wb_way held stable until wb_ready.
  - Transfer cycle is wb_valid & wb_ready; next state WRITE.
  - No timeout.
- WRITE (1 cycle): ts_write_en=1, ts_tag=captured tag, ts_way=chosen way. The tag store sets valid=1 and clears dirty.
  - If merged dirty: go to MARK.
  - Else: ev_done=1, ev_way=chosen way, go to IDLE.
- MARK (1 cycle): ts_dirty_set=1 on the chosen way; ev_done=1; go to IDLE.
- Insert latency, clean, no writeback: accept T, ev_done T+2.
- ts_read_en and ts_dirty_clear are tied to 0 in the base build.

Optional Feature:
- Macro VC_STATS_EN.
- Defined: adds outputs stat_hits, stat_misses, stat_wbs, each 16 bits.
  - Counters are saturating at 0xFFFF and reset to 0.
  - They increment in RESP (hit/miss) and on the WB transfer cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package vc_pkg holds:
  - the state enum (IDLE, LOOKUP, RESP, SELECT, WB, WRITE, MARK);
  - the default TAG_WIDTH/NUM_WAYS localparams;
  - the stats counter width of 16.
- Sub-module vc_victim_sel (combinational) takes valid_vec, hit, hit_way and rr_ptr, and produces way plus need_wb.

Test Plan:
- After reset, lk_req tag=0x5 into an empty store → resp_valid at T+2, resp_hit=0, resp_way=0, no ts_valid_clear.
- Insert tags 0x1..0x4 clean → ev_way=0,1,2,3 in order, each ev_done at T+2, no wb_valid.
- With all ways valid and way 0 dirty, insert 0x9 → wb_valid with wb_way=0.
  - Hold wb_ready=0 for 3 cycles: wb_valid and wb_way stay stable.
  - Then write way 0; rr_ptr becomes 1.
- Lookup 0x3 (way 2, dirty) → resp_hit=1, resp_way=2, resp_dirty=1, ts_valid_clear on way 2 in the RESP cycle.
- lk_req and ev_req in the same cycle → lookup served first, ev_ready=0 until IDLE; then insert with ev_dirty=1 → ts_write_en then ts_dirty_set, ev_done at T+3.
- Assert rst during WB → next cycle wb_valid=0, state IDLE, rr_ptr=0; stats zero when VC_STATS_EN is defined.
